data_sync_tx: RTL and testbench

Source-side sender for the multi-bit data synchronizer. Accepts a word from local logic, drives it onto UNSYNC_BUS and holds it stable, and raises BUS_ENABLE as a level request. It then completes a 4-phase handshake against the destination's acknowledge, which it synchronizes internally, and only then releases the bus for the next word. It sits in the source clock domain, directly upstream of the destination-domain synchronizer.

---
 rtl/data_sync_tx.sv | 156 +++++++++++++++
 tb/tb_data_sync_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_tx.sv
// data_sync_tx: source-side sender for the multi-bit data synchronizer.
// It latches a word onto UNSYNC_BUS, raises BUS_ENABLE as a level request,
// and completes a 4-phase handshake against a locally synchronized ACK_ASYNC.
// Optional feature macro: DATA_SYNC_TX_TIMEOUT_EN adds a per-phase handshake
// timeout that reports on TX_ERR. Without it, TX_ERR is constant 0.
module data_sync_tx #(
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    output logic                 BUS_ENABLE,
    input  logic                 ACK_ASYNC,
    output logic                 TX_DONE,
    output logic                 TX_ERR
);

    // Reject configurations the synchronizer chain or timeout cannot support.
    if (NUM_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("data_sync_tx: NUM_STAGES and TIMEOUT_CYCLES must both be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [BUS_WIDTH-1:0]   bus_q;
    logic                   bus_en_q;
    logic                   done_q;
    logic                   err_q;
    logic [NUM_STAGES-1:0]  ack_sync_q;
    logic                   ack_sync_s;
    logic                   timeout_s;

    assign ack_sync_s = ack_sync_q[NUM_STAGES-1];

    // Bring the asynchronous acknowledge level into CLK through a flop chain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], ACK_ASYNC};
        end
    end

`ifdef DATA_SYNC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hold_s;

    // A phase is "held" while its exit condition has not yet been observed.
    always_comb begin
        hold_s = 1'b0;
        if (state_q == ST_REQ) begin
            hold_s = ~ack_sync_s;
        end else if (state_q == ST_REL) begin
            hold_s = ack_sync_s;
        end else begin
            hold_s = 1'b0;
        end
    end

    // The last waiting cycle of a phase is when the count reaches TIMEOUT_CYCLES-1.
    assign timeout_s = hold_s && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count waiting cycles; any state change (exit, timeout, idle) clears it.
    always_comb begin
        cnt_d = '0;
        if (hold_s && !timeout_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Register the phase timeout counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Handshake FSM: owns the bus word, the request level and the status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            bus_q    <= '0;
            bus_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (TX_VALID) begin
                        bus_q    <= TX_DATA;
                        bus_en_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (ack_sync_s) begin
                        bus_en_q <= 1'b0;
                        state_q  <= ST_REL;
                    end else if (timeout_s) begin
                        bus_en_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= ST_REL;
                    end else begin
                        state_q  <= ST_REQ;
                    end
                end
                ST_REL: begin
                    if (!ack_sync_s) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (timeout_s) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_REL;
                    end
                end
                default: begin
                    bus_en_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_READY   = (state_q == ST_IDLE);
    assign UNSYNC_BUS = bus_q;
    assign BUS_ENABLE = bus_en_q;
    assign TX_DONE    = done_q;
    assign TX_ERR     = err_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Self-checking bench for data_sync_tx (NUM_STAGES=2, TIMEOUT_CYCLES=16).
// Table of per-cycle vectors with a hand-driven acknowledge, hand-written
// multi-cycle sequences, and a randomized loopback run against a timing model.
module tb_data_sync_tx;

    localparam int BW = 8;
    localparam int NS = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic [BW-1:0] tx_data;
    logic          tx_ready;
    logic [BW-1:0] unsync_bus;
    logic          bus_enable;
    logic          tx_done;
    logic          tx_err;
    logic          loop_en;
    logic          ack_man;
    logic          ack_w;

    int n_pass  = 0;
    int n_total = 0;

    assign ack_w = loop_en ? bus_enable : ack_man;

    data_sync_tx #(
        .BUS_WIDTH      (BW),
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .TX_DATA    (tx_data),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready),
        .UNSYNC_BUS (unsync_bus),
        .BUS_ENABLE (bus_enable),
        .ACK_ASYNC  (ack_w),
        .TX_DONE    (tx_done),
        .TX_ERR     (tx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [BW-1:0] data;
        logic          ack;
        logic          rdy;
        logic          be;
        logic [BW-1:0] bus;
        logic          done;
    } vec_t;

    vec_t vt [22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic be,
                            input logic [BW-1:0] bus, input logic done, input logic err);
        chk({tag, ".ready"}, 32'(tx_ready),   32'(rdy));
        chk({tag, ".be"},    32'(bus_enable), 32'(be));
        chk({tag, ".bus"},   32'(unsync_bus), 32'(bus));
        chk({tag, ".done"},  32'(tx_done),    32'(done));
        chk({tag, ".err"},   32'(tx_err),     32'(err));
    endtask

    // One loopback transfer from idle: accept edge k, then the spec schedule.
    task automatic loop_xfer(input string tag, input logic [BW-1:0] word);
        loop_en  = 1'b1;
        tx_valid = 1'b1;
        tx_data  = word;
        for (int j = 0; j <= 2 * NS + 3; j++) begin
            step();
            tx_valid = 1'b0;
            tx_data  = 8'h00;
            chk_outs($sformatf("%s.k+%0d", tag, j),
                     (j >= 2 * NS + 2), (j <= NS), word, (j == 2 * NS + 2), 1'b0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        loop_en  = 1'b0;
        ack_man  = 1'b0;

        // Reset held two edges with TX_VALID asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            chk_outs($sformatf("reset%0d", i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Hand-driven acknowledge vectors: normal handshake, ignored valid, stale ack.
        vt[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
        vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1};
        vt[7]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};
        vt[8]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0};
        vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0};
        vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0};
        vt[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1};
        vt[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0};
        vt[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0};
        vt[17] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0};
        vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0};
        vt[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0};
        vt[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0};
        vt[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1};
        for (int r = 0; r < 22; r++) begin
            tx_valid = vt[r].valid;
            tx_data  = vt[r].data;
            ack_man  = vt[r].ack;
            step();
            chk_outs($sformatf("vec%0d", r), vt[r].rdy, vt[r].be, vt[r].bus, vt[r].done, 1'b0);
        end
        tx_valid = 1'b0;
        ack_man  = 1'b0;

        // Loopback transfer of 8'hBC.
        loop_xfer("loop_bc", 8'hBC);

        // Back-to-back words with TX_VALID held high.
        begin
            logic [BW-1:0] words [3];
            int acc_cyc [$];
            int idx;
            int dones;
            logic rdy_before;
            words[0] = 8'h11;
            words[1] = 8'h22;
            words[2] = 8'h33;
            idx   = 0;
            dones = 0;
            loop_en  = 1'b1;
            tx_valid = 1'b1;
            tx_data  = words[0];
            for (int c = 0; c < 30; c++) begin
                rdy_before = tx_ready;
                step();
                if (rdy_before && tx_valid) begin
                    acc_cyc.push_back(c);
                    chk($sformatf("b2b.word%0d", idx), 32'(unsync_bus), 32'(words[idx]));
                    idx++;
                    if (idx == 3) begin
                        tx_valid = 1'b0;
                        tx_data  = 8'h00;
                    end else begin
                        tx_data = words[idx];
                    end
                end
                if (tx_done) begin
                    dones++;
                end
            end
            chk("b2b.accepts", 32'(idx), 32'd3);
            chk("b2b.dones", 32'(dones), 32'd3);
            if (acc_cyc.size() == 3) begin
                chk("b2b.gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
                chk("b2b.gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd7);
            end else begin
                chk("b2b.accept_count", 32'(acc_cyc.size()), 32'd3);
            end
        end

        // Slow acknowledge: raised 20 cycles after request, dropped 15 after release.
        loop_en  = 1'b0;
        ack_man  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h6E;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        chk_outs("slow.accept", 1'b0, 1'b1, 8'h6E, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            step();
            chk_outs($sformatf("slow.req%0d", i), 1'b0, 1'b1, 8'h6E, 1'b0, 1'b0);
        end
        ack_man = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs($sformatf("slow.ack%0d", i), 1'b0, (i < 2), 8'h6E, 1'b0, 1'b0);
        end
        for (int i = 1; i < 15; i++) begin
            step();
            chk_outs($sformatf("slow.rel%0d", i), 1'b0, 1'b0, 8'h6E, 1'b0, 1'b0);
        end
        ack_man = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs($sformatf("slow.drop%0d", i), (i == 2), 1'b0, 8'h6E, (i == 2), 1'b0);
        end

        // Reset asserted while in REL, then a clean transfer of 8'hA5.
        loop_en  = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h5C;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk_outs("midrst.in_rel", 1'b0, 1'b0, 8'h5C, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_outs("midrst.reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs($sformatf("midrst.after%0d", i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        loop_xfer("midrst.a5", 8'hA5);

        // Acknowledge stuck low.
        loop_en  = 1'b0;
        ack_man  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
`ifdef DATA_SYNC_TX_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            step();
            chk_outs($sformatf("tmo.req%0d", i), 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        end
        step();
        chk_outs("tmo.fire", 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
        step();
        chk("tmo.err_clear", 32'(tx_err), 32'd0);
        chk("tmo.idle", 32'(tx_ready), 32'd1);
`else
        begin
            int bad_be;
            int bad_err;
            bad_be  = 0;
            bad_err = 0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (bus_enable !== 1'b1 || tx_ready !== 1'b0) bad_be++;
                if (tx_err !== 1'b0) bad_err++;
            end
            chk("stuck.be_held_cycles_bad", 32'(bad_be), 32'd0);
            chk("stuck.err_cycles_bad", 32'(bad_err), 32'd0);
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk_outs("stuck.reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        end
`endif

        // Randomized loopback run against the schedule model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        loop_en = 1'b1;
        begin
            int            acc;
            logic [BW-1:0] mbus;
            logic          v;
            logic [BW-1:0] d;
            logic          mready;
            acc  = -1000;
            mbus = 8'h00;
            for (int e = 0; e < 500; e++) begin
                v  = ($urandom_range(0, 2) != 0);
                d  = 8'($urandom);
                tx_valid = v;
                tx_data  = d;
                mready = !((e - 1 >= acc) && (e - 1 < acc + 2 * NS + 2));
                step();
                if (mready && v) begin
                    acc  = e;
                    mbus = d;
                end
                chk_outs($sformatf("rand%0d", e),
                         !((e >= acc) && (e < acc + 2 * NS + 2)),
                         (e >= acc) && (e <= acc + NS),
                         mbus,
                         (e == acc + 2 * NS + 2),
                         1'b0);
            end
            tx_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
